// File: rtl/glb_ld_dma_sched.sv
// Load-DMA header queue scheduler: walks the tile's header slots in order, offers each
// valid header to the load-DMA engine and invalidates the slot once its transfer completes.
module glb_ld_dma_sched #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int XFER_CNT_WIDTH = 16,
  parameter int HDR_DATA_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [1:0]                                    cfg_ld_dma_mode,
  // Slot i occupies bits [i*(HDR_DATA_WIDTH+1) +: HDR_DATA_WIDTH+1]; its MSB is the validate bit.
  input  logic [QUEUE_DEPTH*(HDR_DATA_WIDTH+1)-1:0]     cfg_ld_dma_header,
  input  logic                                          ld_dma_start_pulse,
  output logic [QUEUE_DEPTH-1:0]                        cfg_load_dma_invalidate_pulse,
  output logic [HDR_DATA_WIDTH:0]                       dma_hdr,
  output logic                                          dma_hdr_valid,
  input  logic                                          dma_hdr_ready,
  input  logic                                          dma_done_pulse,
  output logic                                          ld_dma_done_pulse,
  output logic                                          sched_busy,
  output logic [$clog2(QUEUE_DEPTH)-1:0]                cur_queue_idx,
  output logic [XFER_CNT_WIDTH-1:0]                     xfer_cnt
);

  localparam int HDR_W = HDR_DATA_WIDTH + 1;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [1:0] MODE_QUEUE  = 2'b01;
  localparam logic [1:0] MODE_REPEAT = 2'b10;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [HDR_W-1:0]          hdr_q, hdr_d;
  logic                      hdr_valid_q, hdr_valid_d;
  logic [QUEUE_DEPTH-1:0]    inval_q, inval_d;
  logic                      done_q, done_d;
  logic [XFER_CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

  logic [HDR_W-1:0]          slot_hdr [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]    slot_valid;

  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
      assign slot_hdr[gi]   = cfg_ld_dma_header[gi*HDR_W +: HDR_W];
      assign slot_valid[gi] = cfg_ld_dma_header[gi*HDR_W + HDR_W - 1];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    hdr_d       = hdr_q;
    hdr_valid_d = hdr_valid_q;
    inval_d     = '0;
    done_d      = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ld_dma_start_pulse &&
            (cfg_ld_dma_mode == MODE_QUEUE || cfg_ld_dma_mode == MODE_REPEAT)) begin
          mode_d     = cfg_ld_dma_mode;
          ptr_d      = '0;
          xfer_cnt_d = '0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        // A mode change made during a run is only honoured here, between transfers.
        if (cfg_ld_dma_mode != mode_q || !slot_valid[ptr_q]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          hdr_d       = slot_hdr[ptr_q];
          hdr_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dma_hdr_ready) begin
          hdr_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dma_done_pulse) begin
          if (!(&xfer_cnt_q)) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
          end
          if (mode_q == MODE_QUEUE) begin
            inval_d[ptr_q] = 1'b1;
            ptr_d          = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          end else begin
            ptr_d = '0;
          end
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      ptr_q       <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      inval_q     <= '0;
      done_q      <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      inval_q     <= inval_d;
      done_q      <= done_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign cfg_load_dma_invalidate_pulse = inval_q;
  assign dma_hdr                       = hdr_q;
  assign dma_hdr_valid                 = hdr_valid_q;
  assign ld_dma_done_pulse             = done_q;
  assign sched_busy                    = (state_q != S_IDLE);
  assign cur_queue_idx                 = ptr_q;
  assign xfer_cnt                      = xfer_cnt_q;

endmodule

// File: doc/glb_ld_dma_sched.md
# glb_ld_dma_sched

Load-DMA header queue scheduler for one GLB tile. It watches the `QUEUE_DEPTH` load-DMA headers held by the tile configuration registers and hands valid headers to the tile's load-DMA engine in queue order, one at a time. When a transfer completes it fires the per-entry invalidate pulse back to the configuration block, which clears the header's validate bit. It sits between the tile config block and the load-DMA datapath, and also provides a queue-drained pulse for interrupt logic.

## Interface

Clock `clk`; reset `reset` is synchronous and active-high.

**Parameters**
- `QUEUE_DEPTH`, default 4. Number of load-DMA header slots; minimum 2.
- `XFER_CNT_WIDTH`, default 16. Width of the completed-transfer counter.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1. Clock.
- `reset`, in, 1. Synchronous, active-high reset.
- `cfg_ld_dma_mode`, in, 2. Mode select: `00` = OFF, `01` = QUEUE, `10` = REPEAT, `11` = reserved (treated as OFF).
- `cfg_ld_dma_header`, in, `dma_ld_header_t [QUEUE_DEPTH]`. Header slots; `.valid` is the validate bit.
- `ld_dma_start_pulse`, in, 1. Arms the scheduler.
- `cfg_load_dma_invalidate_pulse`, out, 1 x `[QUEUE_DEPTH]`. One-cycle per-slot clear pulse.
- `dma_hdr`, out, `dma_ld_header_t`. Header presented to the engine.
- `dma_hdr_valid`, out, 1. Offer valid.
- `dma_hdr_ready`, in, 1. Engine accepts the offer.
- `dma_done_pulse`, in, 1. Engine finished the accepted transfer.
- `ld_dma_done_pulse`, out, 1. Scheduler run ended.
- `sched_busy`, out, 1. High in any state other than IDLE.
- `cur_queue_idx`, out, `$clog2(QUEUE_DEPTH)`. Slot pointer.
- `xfer_cnt`, out, `XFER_CNT_WIDTH`. Transfers completed in the current run.

## Operation

**States:** IDLE, CHECK, ISSUE, WAIT.

- **IDLE**
  - On `ld_dma_start_pulse` with mode QUEUE or REPEAT, go to CHECK.
  - Starting a run clears `xfer_cnt` to 0 and sets the pointer to 0.
  - A start pulse under OFF or reserved mode is ignored.
- **CHECK**
  - Evaluates `cfg_ld_dma_mode` and `cfg_ld_dma_header[ptr].valid` combinationally.
  - If the mode is not the one sampled at start, or the slot is invalid: pulse `ld_dma_done_pulse` and go to IDLE.
  - Otherwise register `dma_hdr` from the slot and go to ISSUE.
- **ISSUE**
  - `dma_hdr_valid` is high and `dma_hdr` is held stable until `dma_hdr_ready`.
  - On ready, go to WAIT. Valid drops the next cycle.
- **WAIT**
  - On `dma_done_pulse`, `xfer_cnt` increments, saturating at all-ones.
  - QUEUE mode: the next cycle pulses `cfg_load_dma_invalidate_pulse[ptr]` for one cycle, the pointer advances (ptr+1, wrapping `QUEUE_DEPTH-1` back to 0), and the state goes to CHECK. The invalidate pulse and the CHECK of the new pointer occur in the same cycle.
  - REPEAT mode: the pointer stays 0, no invalidate is issued, and the state goes to CHECK.

**Rules**
- `dma_done_pulse` is ignored outside WAIT, including in the ISSUE cycle where ready is high.
- `ld_dma_start_pulse` is ignored while `sched_busy` is high.
- A mode change is never acted on mid-transfer. It takes effect only at the next CHECK.
- An empty queue at start produces: CHECK, then `ld_dma_done_pulse`, then IDLE, with no offer made.
- QUEUE mode keeps wrapping while the host re-validates slots. It stops at the first invalid slot reached.
- At most one bit of `cfg_load_dma_invalidate_pulse` is high in any cycle.

## Timing

**Reset values:** state IDLE, pointer 0, `dma_hdr` = 0, `dma_hdr_valid` = 0, all invalidate pulses 0, `ld_dma_done_pulse` = 0, `sched_busy` = 0, `cur_queue_idx` = 0, `xfer_cnt` = 0.

**Latency**
- Start pulse at cycle T: CHECK at T+1, `dma_hdr_valid` at T+2.
- Ready at cycle R: WAIT from R+1.
- Done at cycle D: invalidate pulse and CHECK at D+1, next `dma_hdr_valid` at D+2.
- Queue drained at CHECK cycle C: `ld_dma_done_pulse` is high during cycle C+1, which is the first IDLE cycle. `sched_busy` is low from C+1.

**Reset mid-operation:** everything returns to reset values on the next edge. No invalidate pulse and no done pulse are emitted.

**Output registration:** all outputs are registered except `sched_busy` and `cur_queue_idx`, which are decoded from registered state.

## Test plan

- **QUEUE run, two valid slots.** Mode `01`, slots 0 and 1 valid, start at T, ready immediate, done 5 cycles after acceptance. Expect: `dma_hdr_valid` at T+2; invalidate[0] and invalidate[1] each one cycle; `ld_dma_done_pulse` once; `xfer_cnt` = 2.
- **Backpressure.** Hold ready low for 10 cycles. Expect: `dma_hdr_valid` and `dma_hdr` stable the whole time; a `dma_done_pulse` injected during ISSUE is ignored and `xfer_cnt` is unchanged.
- **Wrap.** `QUEUE_DEPTH` = 4, all 4 slots valid; the host re-validates slot 0 before the 4th done. Expect: 5 transfers, pointer sequence 0,1,2,3,0, stop at slot 1, `xfer_cnt` = 5.
- **REPEAT mode.** Mode `10`, slot 0 valid, 3 transfers, then mode switched to `00` during WAIT. Expect: no invalidate pulses; the third transfer completes; the next CHECK ends the run with `ld_dma_done_pulse`; `xfer_cnt` = 3.
- **Empty queue and ignored starts.** Start with no valid slots: `ld_dma_done_pulse` at T+2 and no offer. A start in mode `11` is ignored (`sched_busy` stays 0). A start while busy is ignored.
- **Reset in WAIT.** Assert `reset` while in WAIT. Expect: all outputs equal reset values the next cycle, and no invalidate pulse.
